// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    DM_BUSY,
    DONE
  } arb_state_e;

  typedef enum logic {
    REQ_IF,
    REQ_DM
  } req_id_e;

  localparam int DEFAULT_MAX_STREAK = 4;
  localparam int DEFAULT_TIMEOUT    = 64;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector: DM wins unless IF has waited through MAX_STREAK DM grants.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_STREAK = DEFAULT_MAX_STREAK,
  parameter int SW         = $clog2(MAX_STREAK + 1)
) (
  input  logic          if_req_i,
  input  logic          dm_req_i,
  input  logic [SW-1:0] streak_i,
  output logic          grant_valid_o,
  output req_id_e       grant_id_o
);

  logic forceIf;

  always_comb begin
    forceIf       = if_req_i & (streak_i == SW'(MAX_STREAK));
    grant_valid_o = if_req_i | dm_req_i;
    grant_id_o    = (dm_req_i & ~forceIf) ? REQ_DM : REQ_IF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (read-only) and data memory.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STREAK = DEFAULT_MAX_STREAK,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_ack_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic [DW-1:0] dm_rdata_o,
  output logic          dm_ack_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i,
  output logic          err_o,
  output logic          busy_o
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic          err_q, err_d;

  logic    grantValid;
  req_id_e grantId;

  mem_arb_pick #(
    .MAX_STREAK (MAX_STREAK),
    .SW         (SW)
  ) u_pick (
    .if_req_i      (if_req_i),
    .dm_req_i      (dm_req_i),
    .streak_i      (streak_q),
    .grant_valid_o (grantValid),
    .grant_id_o    (grantId)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      timer_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      timer_q     <= timer_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    timer_d     = timer_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grantValid) begin
          mem_req_d = 1'b1;
          timer_d   = '0;
          if (grantId == REQ_DM) begin
            state_d     = DM_BUSY;
            mem_we_d    = dm_we_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
            if (if_req_i && (streak_q != SW'(MAX_STREAK))) begin
              streak_d = streak_q + SW'(1);
            end
          end else begin
            state_d     = IF_BUSY;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
            streak_d    = '0;
          end
        end
      end

      IF_BUSY, DM_BUSY: begin
        // Ready has precedence over an expiring timer in the same cycle.
        if (mem_ready_i || (timer_q == TW'(TIMEOUT - 1))) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          err_d     = ~mem_ready_i;
          if (state_q == IF_BUSY) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ready_i ? mem_rdata_i : '0;
          end else begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = (mem_ready_i && !mem_we_q) ? mem_rdata_i : '0;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (MAX_STREAK=2, TIMEOUT=8) with a simple memory responder.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        dm_req_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ready_i = 1'b0;
  logic        err_o;
  logic        busy_o;

  typedef struct {
    bit          isDm;
    logic [31:0] rdata;
    bit          err;
    int          expCycle;
  } expEntry_t;

  expEntry_t expQ[$];
  int errCount   = 0;
  int checkCount = 0;
  int cyc        = 0;
  int waitCycles = 1;
  bit neverReady = 1'b0;
  int busyCnt    = 0;

  mem_port_arbiter #(
    .AW(32), .DW(32), .MAX_STREAK(2), .TIMEOUT(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  function automatic logic [31:0] rdataFor(input logic [31:0] a);
    case (a)
      32'h10:  rdataFor = 32'hDEAD_BEEF;
      32'h40:  rdataFor = 32'hCAFE_F00D;
      32'h20:  rdataFor = 32'h1111_2222;
      default: rdataFor = 32'h5555_AAAA;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: ready after waitCycles BUSY cycles, data looked up by address.
  initial forever begin
    @(negedge clk_i);
    if (mem_req_o && !neverReady) begin
      busyCnt++;
      mem_ready_i = (busyCnt >= waitCycles);
      mem_rdata_i = rdataFor(mem_addr_o);
    end else begin
      if (!mem_req_o) busyCnt = 0;
      mem_ready_i = 1'b0;
      mem_rdata_i = 32'h0BAD_0BAD;
    end
  end

  // Monitor: every ack pops one expected entry from the scoreboard.
  initial forever begin
    @(negedge clk_i);
    if (rst_i) begin
      if (if_ack_o && dm_ack_o) checkOutput("bothAcks", 2'b11, 2'b01);
      if (if_ack_o || dm_ack_o) begin
        if (expQ.size() == 0) begin
          checkCount++;
          errCount++;
          $display("[TB] FAIL unexpectedAck: if_ack=%0b dm_ack=%0b with no pending entry (cycle %0d)",
                   if_ack_o, dm_ack_o, cyc);
        end else begin
          expEntry_t e;
          e = expQ.pop_front();
          checkOutput("ackId", {63'd0, dm_ack_o}, {63'd0, e.isDm});
          checkOutput("rdata", dm_ack_o ? dm_rdata_o : if_rdata_o, e.rdata);
          checkOutput("errWithAck", err_o, e.err);
          if (e.expCycle >= 0) checkOutput("ackCycle", cyc, e.expCycle);
        end
      end else if (err_o) begin
        checkOutput("errWithoutAck", err_o, 1'b0);
      end
    end
  end

  task automatic applyStimulus(input bit isDm, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expRdata,
                               input bit expErr, output int reqCycles);
    bit got;
    expQ.push_back('{isDm, expRdata, expErr, -1});
    @(negedge clk_i);
    if (isDm) begin
      dm_req_i = 1'b1; dm_we_i = we; dm_addr_i = addr; dm_wdata_i = wdata;
    end else begin
      if_req_i = 1'b1; if_addr_i = addr;
    end
    reqCycles = 0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_i);
      if (mem_req_o) begin
        reqCycles++;
        checkOutput("memWe", mem_we_o, we);
        checkOutput("memAddr", mem_addr_o, addr);
        if (we) checkOutput("memWdata", mem_wdata_o, wdata);
        if (reqCycles == 1) begin
          dm_addr_i = ~addr; dm_wdata_i = ~wdata; dm_we_i = ~we; if_addr_i = ~addr;
        end
      end
      if ((isDm && dm_ack_o) || (!isDm && if_ack_o)) got = 1'b1;
    end
    if (!got) checkOutput("ackTimeout", 1'b0, 1'b1);
    if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rc;
    int c0;
    int acks;
    bit ifDone, dmDone;

    // Reset state
    repeat (2) @(negedge clk_i);
    checkOutput("rstMemReq", mem_req_o, 0);
    checkOutput("rstBusy", busy_o, 0);
    checkOutput("rstAcks", {if_ack_o, dm_ack_o, err_o}, 0);
    checkOutput("rstBus", {mem_we_o, mem_addr_o, mem_wdata_o}, 0);
    checkOutput("rstRdata", {if_rdata_o, dm_rdata_o}, 0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // IF-only read, ready two cycles after mem_req rises
    $display("[TB] IF read with 2-cycle memory");
    waitCycles = 2;
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, rc);
    checkOutput("ifReqCycles", rc, 2);
    @(negedge clk_i);
    checkOutput("ifAckOneCycle", if_ack_o, 0);
    checkOutput("idleAfterIf", busy_o, 0);

    // Simultaneous requests, zero-wait: DM ack 2 cycles after request cycle, IF 3 later
    $display("[TB] simultaneous IF and DM");
    waitCycles = 1;
    @(negedge clk_i);
    c0 = cyc;
    expQ.push_back('{1'b1, 32'hCAFE_F00D, 1'b0, c0 + 2});
    expQ.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0, c0 + 5});
    if_req_i = 1'b1; if_addr_i = 32'h10;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40;
    ifDone = 1'b0; dmDone = 1'b0;
    for (int i = 0; i < 50 && !(ifDone && dmDone); i++) begin
      @(negedge clk_i);
      if (dm_ack_o) begin dmDone = 1'b1; dm_req_i = 1'b0; end
      if (if_ack_o) begin ifDone = 1'b1; if_req_i = 1'b0; end
    end
    checkOutput("simulBothDone", {ifDone, dmDone}, 2'b11);
    if_req_i = 1'b0; dm_req_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Starvation guard with MAX_STREAK=2: DM, DM, IF, DM, DM, IF
    $display("[TB] starvation guard");
    c0 = cyc;
    for (int k = 0; k < 6; k++) begin
      if ((k % 3) == 2) expQ.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0, c0 + 2 + 3 * k});
      else              expQ.push_back('{1'b1, 32'hCAFE_F00D, 1'b0, c0 + 2 + 3 * k});
    end
    if_req_i = 1'b1; if_addr_i = 32'h10;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40;
    acks = 0;
    for (int i = 0; i < 100 && acks < 6; i++) begin
      @(negedge clk_i);
      if (if_ack_o || dm_ack_o) acks++;
    end
    if_req_i = 1'b0; dm_req_i = 1'b0;
    checkOutput("streakAcks", acks, 6);
    repeat (2) @(negedge clk_i);

    // DM write with 3-cycle memory; bus must stay stable while inputs change
    $display("[TB] DM write");
    waitCycles = 3;
    applyStimulus(1'b1, 1'b1, 32'h80, 32'h1234, 32'h0, 1'b0, rc);
    checkOutput("wrReqCycles", rc, 3);
    @(negedge clk_i);

    // Timeout: memory never ready, DONE after 8 BUSY cycles with err
    $display("[TB] timeout");
    neverReady = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, rc);
    checkOutput("toReqCycles", rc, 8);
    @(negedge clk_i);
    neverReady = 1'b0;
    waitCycles = 1;
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 32'h1111_2222, 1'b0, rc);
    checkOutput("postToReqCycles", rc, 1);
    @(negedge clk_i);

    // Reset in the middle of a DM access
    $display("[TB] reset mid-access");
    neverReady = 1'b1;
    @(negedge clk_i);
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40;
    repeat (3) @(negedge clk_i);
    checkOutput("busyBeforeRst", busy_o, 1);
    rst_i = 1'b0;
    #1;
    checkOutput("asyncRstMemReq", mem_req_o, 0);
    checkOutput("asyncRstBusy", busy_o, 0);
    checkOutput("asyncRstBus", {mem_we_o, mem_addr_o, mem_wdata_o}, 0);
    checkOutput("asyncRstRdata", {if_rdata_o, dm_rdata_o}, 0);
    dm_req_i = 1'b0; dm_addr_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    neverReady = 1'b0;
    repeat (6) @(negedge clk_i);
    checkOutput("idleAfterRst", busy_o, 0);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, rc);
    repeat (3) @(negedge clk_i);

    checkOutput("scoreboardEmpty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
